mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read 64-bit memory between the core's instruction-fetch port and its load/store port. Sits between the core and the unified memory macro and replaces the separate same-cycle imem/dmem model. Each access takes two cycles. Data accesses win arbitration by default, and a starvation counter bounds how long fetch can be locked out. Misaligned requests are answered with an error and never touch memory.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_starve_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encodings, alignment masks
// and doubleword address truncation, kept here so the future cache controller can reuse them.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_WAIT = 3'd1,
    LS_WAIT = 3'd2,
    ERR_IF  = 3'd3,
    ERR_LS  = 3'd4
  } arb_state_e;

  localparam logic [1:0]  IF_ALIGN_MASK = 2'b11;
  localparam logic [2:0]  LS_ALIGN_MASK = 3'b111;
  localparam logic [63:0] DW_ADDR_MASK  = 64'hFFFF_FFFF_FFFF_FFF8;

  function automatic logic [63:0] dw_addr(input logic [63:0] addr);
    return addr & DW_ADDR_MASK;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch and load/store handshakes plus the memory-macro port of the arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_arbiter_if;
  logic        i_if_req;
  logic [63:0] i_if_addr;
  logic        o_if_ready;
  logic [31:0] o_if_rdata;
  logic        o_if_err;

  logic        i_ls_ren;
  logic        i_ls_wen;
  logic [63:0] i_ls_addr;
  logic [63:0] i_ls_wdata;
  logic        o_ls_ready;
  logic [63:0] o_ls_rdata;
  logic        o_ls_err;

  logic        o_mem_en;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [63:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_ls_ren, i_ls_wen, i_ls_addr, i_ls_wdata, i_mem_rdata,
    output o_if_ready, o_if_rdata, o_if_err, o_ls_ready, o_ls_rdata, o_ls_err,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_if_req, i_if_addr, i_ls_ren, i_ls_wen, i_ls_addr, i_ls_wdata, i_mem_rdata,
    input  o_if_ready, o_if_rdata, o_if_err, o_ls_ready, o_ls_rdata, o_ls_err,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_starve_counter.sv
// Saturating 4-bit count of data grants that overtook a pending fetch; at_limit
// tells the arbiter to hand fetch its forced win.
module arb_starve_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic       i_clr,
  input  logic [3:0] i_limit,
  output logic       o_at_limit
);

  logic [3:0] cnt_q, cnt_d;

  // NOTE: every combinational output gets its default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q < i_limit)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_at_limit = (cnt_q >= i_limit);

endmodule

// File: rtl/mem_arbiter.sv
// Two-cycle arbiter sharing one synchronous-read 64-bit memory between instruction
// fetch and load/store; data wins by default, a starvation counter bounds fetch lockout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic       lane_q, lane_d;
  logic       store_q, store_d;

  logic if_pend, ls_pend, if_misal, ls_misal;
  logic grant_if, grant_ls, at_limit;

  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        if_ready, if_err, ls_ready, ls_err;
  logic [31:0] if_rdata;
  logic [63:0] ls_rdata;

  assign if_pend  = bus.i_if_req;
  assign ls_pend  = bus.i_ls_ren | bus.i_ls_wen;
  assign if_misal = |(bus.i_if_addr[1:0] & IF_ALIGN_MASK);
  assign ls_misal = |(bus.i_ls_addr[2:0] & LS_ALIGN_MASK);

  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == IDLE) begin
      if (ls_pend && !at_limit) grant_ls = 1'b1;
      else if (if_pend)         grant_if = 1'b1;
      else if (ls_pend)         grant_ls = 1'b1;
    end
  end

  arb_starve_counter u_starve (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      (grant_ls & if_pend),
    .i_clr      (grant_if),
    .i_limit    (LIMIT),
    .o_at_limit (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    store_d   = store_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ready  = 1'b0;
    if_err    = 1'b0;
    if_rdata  = '0;
    ls_ready  = 1'b0;
    ls_err    = 1'b0;
    ls_rdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_if) begin
          lane_d = bus.i_if_addr[2];
          if (if_misal) begin
            state_d = ERR_IF;
          end else begin
            mem_en   = 1'b1;
            mem_addr = dw_addr(bus.i_if_addr);
            state_d  = IF_WAIT;
          end
        end else if (grant_ls) begin
          // Both enables high behaves as a store.
          store_d = bus.i_ls_wen;
          if (ls_misal) begin
            state_d = ERR_LS;
          end else begin
            mem_en    = 1'b1;
            mem_we    = bus.i_ls_wen;
            mem_addr  = dw_addr(bus.i_ls_addr);
            mem_wdata = bus.i_ls_wdata;
            state_d   = LS_WAIT;
          end
        end
      end
      IF_WAIT: begin
        if_ready = 1'b1;
        if_rdata = lane_q ? bus.i_mem_rdata[63:32] : bus.i_mem_rdata[31:0];
        state_d  = IDLE;
      end
      LS_WAIT: begin
        ls_ready = 1'b1;
        ls_rdata = store_q ? 64'h0 : bus.i_mem_rdata;
        state_d  = IDLE;
      end
      ERR_IF: begin
        if_ready = 1'b1;
        if_err   = 1'b1;
        state_d  = IDLE;
      end
      ERR_LS: begin
        ls_ready = 1'b1;
        ls_err   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      lane_q  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      store_q <= store_d;
    end
  end

  // IDLE outputs are Mealy on the requests, so reset must gate them to stay silent.
  assign bus.o_mem_en    = i_rst_n & mem_en;
  assign bus.o_mem_we    = i_rst_n & mem_we;
  assign bus.o_mem_addr  = i_rst_n ? mem_addr  : 64'h0;
  assign bus.o_mem_wdata = i_rst_n ? mem_wdata : 64'h0;
  assign bus.o_if_ready  = i_rst_n & if_ready;
  assign bus.o_if_err    = i_rst_n & if_err;
  assign bus.o_if_rdata  = i_rst_n ? if_rdata  : 32'h0;
  assign bus.o_ls_ready  = i_rst_n & ls_ready;
  assign bus.o_ls_err    = i_rst_n & ls_err;
  assign bus.o_ls_rdata  = i_rst_n ? ls_rdata  : 64'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural synchronous-read memory plus
// per-scenario tasks with hand-computed expectations.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Memory macro model: write on the edge ending the strobe cycle, read data one cycle later.
  logic [63:0] mem_model [0:4095];
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_model[12'h020] <= 64'hAAAA_BBBB_0000_0013;
    end else if (bus.o_mem_en) begin
      if (bus.o_mem_we) mem_model[bus.o_mem_addr[14:3]] <= bus.o_mem_wdata;
      else              bus.i_mem_rdata <= mem_model[bus.o_mem_addr[14:3]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_if_req   = 1'b0;
    bus.i_if_addr  = 64'h0;
    bus.i_ls_ren   = 1'b0;
    bus.i_ls_wen   = 1'b0;
    bus.i_ls_addr  = 64'h0;
    bus.i_ls_wdata = 64'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h100;
    bus.i_ls_ren  = 1'b1;
    bus.i_ls_addr = 64'h2000;
    settle();
    vectors++;
    if ({bus.o_mem_en, bus.o_mem_we, bus.o_if_ready, bus.o_if_err, bus.o_ls_ready, bus.o_ls_err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 000000",
               {bus.o_mem_en, bus.o_mem_we, bus.o_if_ready, bus.o_if_err, bus.o_ls_ready, bus.o_ls_err});
    end
    vectors++;
    if ((bus.o_mem_addr | bus.o_mem_wdata | bus.o_ls_rdata | {32'h0, bus.o_if_rdata}) !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_buses: addr %h wdata %h ls_rdata %h if_rdata %h, want all 0",
               bus.o_mem_addr, bus.o_mem_wdata, bus.o_ls_rdata, bus.o_if_rdata);
    end
    do_reset();
  endtask

  task automatic test_fetch(input logic [63:0] addr, input logic [31:0] exp_word);
    do_reset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = addr;
    settle();
    vectors++;
    if ({bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_if_ready} !== {2'b10, 64'h100, 1'b0}) begin
      miscompares++;
      $display("FAIL fetch_issue@%h: en %b we %b addr %h ready %b, want en 1 we 0 addr 100 ready 0",
               addr, bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_if_ready);
    end
    tick();
    settle();
    vectors++;
    if ({bus.o_if_ready, bus.o_if_err, bus.o_if_rdata, bus.o_ls_ready, bus.o_mem_en} !== {2'b10, exp_word, 2'b00}) begin
      miscompares++;
      $display("FAIL fetch_done@%h: ready %b err %b rdata %h ls_ready %b en %b, want 1 0 %h 0 0",
               addr, bus.o_if_ready, bus.o_if_err, bus.o_if_rdata, bus.o_ls_ready, bus.o_mem_en, exp_word);
    end
    bus.i_if_req = 1'b0;
    tick();
    settle();
    vectors++;
    if (bus.o_if_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_pulse@%h: ready %b want 0", addr, bus.o_if_ready);
    end
  endtask

  task automatic test_store_load();
    do_reset();
    bus.i_ls_wen   = 1'b1;
    bus.i_ls_addr  = 64'h2000;
    bus.i_ls_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    settle();
    vectors++;
    if ({bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata} !== {2'b11, 64'h2000, 64'hDEAD_BEEF_CAFE_F00D}) begin
      miscompares++;
      $display("FAIL store_issue: en %b we %b addr %h wdata %h", bus.o_mem_en, bus.o_mem_we,
               bus.o_mem_addr, bus.o_mem_wdata);
    end
    tick();
    settle();
    vectors++;
    if ({bus.o_ls_ready, bus.o_ls_err, bus.o_ls_rdata, bus.o_mem_we} !== {2'b10, 64'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL store_done: ready %b err %b rdata %h we %b, want 1 0 0 0",
               bus.o_ls_ready, bus.o_ls_err, bus.o_ls_rdata, bus.o_mem_we);
    end
    idle_inputs();
    tick();
    bus.i_ls_ren  = 1'b1;
    bus.i_ls_addr = 64'h2000;
    settle();
    vectors++;
    if ({bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr} !== {2'b10, 64'h2000}) begin
      miscompares++;
      $display("FAIL load_issue: en %b we %b addr %h, want 1 0 2000", bus.o_mem_en, bus.o_mem_we, bus.o_mem_addr);
    end
    tick();
    settle();
    vectors++;
    if ({bus.o_ls_ready, bus.o_ls_rdata, bus.o_mem_we} !== {1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0}) begin
      miscompares++;
      $display("FAIL load_done: ready %b rdata %h we %b, want 1 deadbeefcafef00d 0",
               bus.o_ls_ready, bus.o_ls_rdata, bus.o_mem_we);
    end
    // Both enables: a store that reads back zero.
    idle_inputs();
    tick();
    bus.i_ls_ren   = 1'b1;
    bus.i_ls_wen   = 1'b1;
    bus.i_ls_addr  = 64'h2008;
    bus.i_ls_wdata = 64'h1234_5678_9ABC_DEF0;
    settle();
    vectors++;
    if ({bus.o_mem_en, bus.o_mem_we} !== 2'b11) begin
      miscompares++;
      $display("FAIL rw_issue: en %b we %b, want 1 1", bus.o_mem_en, bus.o_mem_we);
    end
    tick();
    settle();
    vectors++;
    if ({bus.o_ls_ready, bus.o_ls_rdata} !== {1'b1, 64'h0}) begin
      miscompares++;
      $display("FAIL rw_done: ready %b rdata %h, want 1 0", bus.o_ls_ready, bus.o_ls_rdata);
    end
    idle_inputs();
    tick();
  endtask

  // Fetch and load held together with limit 4: data x4 then fetch, fetch done by cycle 9.
  task automatic test_starvation();
    do_reset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h104;
    bus.i_ls_ren  = 1'b1;
    bus.i_ls_addr = 64'h2000;
    for (int c = 0; c < 10; c++) begin
      logic [2:0]  exp_flags;
      logic [63:0] exp_addr;
      exp_flags = {(c % 2 == 0), (c % 2 == 1) && (c != 9), (c == 9)};
      exp_addr  = (c == 8) ? 64'h100 : 64'h2000;
      settle();
      vectors++;
      if ({bus.o_mem_en, bus.o_ls_ready, bus.o_if_ready} !== exp_flags) begin
        miscompares++;
        $display("FAIL starve_flags c%0d: en/ls_ready/if_ready %b want %b", c,
                 {bus.o_mem_en, bus.o_ls_ready, bus.o_if_ready}, exp_flags);
      end
      if (c % 2 == 0) begin
        vectors++;
        if (bus.o_mem_addr !== exp_addr) begin
          miscompares++;
          $display("FAIL starve_grant c%0d: addr %h want %h", c, bus.o_mem_addr, exp_addr);
        end
      end else if (c == 9) begin
        vectors++;
        if (bus.o_if_rdata !== 32'hAAAA_BBBB) begin
          miscompares++;
          $display("FAIL starve_fetch_data: %h want aaaabbbb", bus.o_if_rdata);
        end
        idle_inputs();
      end else begin
        vectors++;
        if (bus.o_ls_rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin
          miscompares++;
          $display("FAIL starve_load_data c%0d: %h want deadbeefcafef00d", c, bus.o_ls_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_misaligned(input logic is_fetch);
    do_reset();
    if (is_fetch) begin
      bus.i_if_req  = 1'b1;
      bus.i_if_addr = 64'h102;
    end else begin
      bus.i_ls_ren  = 1'b1;
      bus.i_ls_addr = 64'h2004;
    end
    settle();
    vectors++;
    if ({bus.o_mem_en, bus.o_if_ready, bus.o_ls_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL misal_issue(fetch=%0b): en/if_ready/ls_ready %b want 000", is_fetch,
               {bus.o_mem_en, bus.o_if_ready, bus.o_ls_ready});
    end
    tick();
    settle();
    vectors++;
    if (is_fetch) begin
      if ({bus.o_mem_en, bus.o_if_ready, bus.o_if_err, bus.o_if_rdata, bus.o_ls_ready} !== {3'b011, 32'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL misal_fetch_done: en %b ready %b err %b rdata %h ls_ready %b, want 0 1 1 0 0",
                 bus.o_mem_en, bus.o_if_ready, bus.o_if_err, bus.o_if_rdata, bus.o_ls_ready);
      end
    end else begin
      if ({bus.o_mem_en, bus.o_ls_ready, bus.o_ls_err, bus.o_ls_rdata, bus.o_if_ready} !== {3'b011, 64'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL misal_load_done: en %b ready %b err %b rdata %h if_ready %b, want 0 1 1 0 0",
                 bus.o_mem_en, bus.o_ls_ready, bus.o_ls_err, bus.o_ls_rdata, bus.o_if_ready);
      end
    end
    idle_inputs();
    tick();
    settle();
    vectors++;
    if ({bus.o_if_ready, bus.o_ls_ready, bus.o_if_err, bus.o_ls_err} !== 4'b0) begin
      miscompares++;
      $display("FAIL misal_pulse(fetch=%0b): ready/err %b want 0000", is_fetch,
               {bus.o_if_ready, bus.o_ls_ready, bus.o_if_err, bus.o_ls_err});
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h104;
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.o_if_ready, bus.o_mem_en, bus.o_if_rdata} !== {2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL midrst_outputs: ready %b en %b rdata %h, want 0 0 0",
               bus.o_if_ready, bus.o_mem_en, bus.o_if_rdata);
    end
    tick();
    rst_n = 1'b1;
    settle();
    vectors++;
    if ({bus.o_mem_en, bus.o_mem_addr, bus.o_if_ready} !== {1'b1, 64'h100, 1'b0}) begin
      miscompares++;
      $display("FAIL midrst_reissue: en %b addr %h ready %b, want 1 100 0",
               bus.o_mem_en, bus.o_mem_addr, bus.o_if_ready);
    end
    tick();
    settle();
    vectors++;
    if ({bus.o_if_ready, bus.o_if_rdata} !== {1'b1, 32'hAAAA_BBBB}) begin
      miscompares++;
      $display("FAIL midrst_done: ready %b rdata %h, want 1 aaaabbbb", bus.o_if_ready, bus.o_if_rdata);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch(64'h104, 32'hAAAA_BBBB);
    test_fetch(64'h100, 32'h0000_0013);
    test_store_load();
    test_starvation();
    test_misaligned(1'b1);
    test_misaligned(1'b0);
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
